gate_ctl: RTL

Frame-synchronous sequencer for the sliding gate between the player and the far side of the level. It arbitrates open requests from two players' buttons and sequences the gate through opening, holding, closing and reversal. It refuses to close while any player stands inside the gate span. Its gate_open output feeds the player movement controllers' pass permission, and gate_height feeds the gate sprite renderer.

---
 rtl/gate_ctl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gate_ctl.sv
// Sliding gate sequencer: arbitrates two players' open requests and steps
// the gate through CLOSED -> OPENING -> OPEN -> CLOSING once per frame
// strobe. Closing pauses or is refused while a player stands in the span.
module gate_ctl #(
    parameter int GATE_X_MIN  = 310,
    parameter int GATE_X_MAX  = 450,
    parameter int GATE_H      = 120,
    parameter int SLIDE_STEP  = 4,
    parameter int HOLD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_tick,
    input  logic        btn_p1,
    input  logic        btn_p2,
    input  logic [11:0] xpos_p1,
    input  logic [11:0] xpos_p2,
    output logic        gate_open,
    output logic [11:0] gate_height,
    output logic [1:0]  gate_state,
    output logic [1:0]  gate_owner,
    output logic [15:0] hold_cnt
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'b00,
        ST_OPENING = 2'b01,
        ST_OPEN    = 2'b10,
        ST_CLOSING = 2'b11
    } state_t;

    localparam logic [11:0] X_MIN     = 12'(GATE_X_MIN);
    localparam logic [11:0] X_MAX     = 12'(GATE_X_MAX);
    localparam logic [11:0] H_FULL    = 12'(GATE_H);
    localparam logic [12:0] H_FULL13  = 13'(GATE_H);
    localparam logic [11:0] STEP      = 12'(SLIDE_STEP);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_FRAMES);

    state_t      state_q, state_d;
    logic        v_tick_d_q;
    logic        gate_open_q, gate_open_d;
    logic [11:0] height_q, height_d;
    logic [1:0]  owner_q, owner_d;
    logic [15:0] hold_q, hold_d;

    logic        strobe;
    logic        req;
    logic        occ;
    logic [12:0] rise_sum;
    logic [11:0] rise_sat;
    logic [11:0] fall_sat;

    // Frame strobe, request and span occupancy seen on this clock.
    always_comb begin
        strobe   = v_tick & ~v_tick_d_q;
        req      = btn_p1 | btn_p2;
        occ      = ((xpos_p1 >= X_MIN) && (xpos_p1 <= X_MAX)) ||
                   ((xpos_p2 >= X_MIN) && (xpos_p2 <= X_MAX));
        // 13-bit sum so a step near the top of the 12-bit range cannot wrap.
        rise_sum = {1'b0, height_q} + {1'b0, STEP};
        rise_sat = (rise_sum >= H_FULL13) ? H_FULL : rise_sum[11:0];
        fall_sat = (height_q > STEP) ? (height_q - STEP) : 12'd0;
    end

    // Next-state and datapath; everything except the edge detector holds
    // between frame strobes.
    always_comb begin
        state_d     = state_q;
        height_d    = height_q;
        owner_d     = owner_q;
        hold_d      = hold_q;
        gate_open_d = gate_open_q;
        if (strobe) begin
            if (req) begin
                owner_d = {btn_p2, btn_p1};
            end
            case (state_q)
                ST_CLOSED: begin
                    height_d = 12'd0;
                    if (req) begin
                        state_d = ST_OPENING;
                    end
                end
                ST_OPENING: begin
                    height_d = rise_sat;
                    if (rise_sat == H_FULL) begin
                        state_d = ST_OPEN;
                        hold_d  = HOLD_LOAD;
                    end
                end
                ST_OPEN: begin
                    height_d = H_FULL;
                    if (req) begin
                        hold_d = HOLD_LOAD;
                    end else if (hold_q != 16'd0) begin
                        hold_d = hold_q - 16'd1;
                    end else if (!occ) begin
                        state_d = ST_CLOSING;
                    end
                end
                ST_CLOSING: begin
                    // A request reverses without moving; climbing resumes
                    // from the current height on the following strobe.
                    if (req) begin
                        state_d = ST_OPENING;
                    end else if (!occ) begin
                        height_d = fall_sat;
                        if (fall_sat == 12'd0) begin
                            state_d = ST_CLOSED;
                        end
                    end
                end
                default: begin
                    state_d  = ST_CLOSED;
                    height_d = 12'd0;
                end
            endcase
            gate_open_d = (state_d == ST_OPEN);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLOSED;
            v_tick_d_q  <= 1'b0;
            gate_open_q <= 1'b0;
            height_q    <= 12'd0;
            owner_q     <= 2'b00;
            hold_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            v_tick_d_q  <= v_tick;
            gate_open_q <= gate_open_d;
            height_q    <= height_d;
            owner_q     <= owner_d;
            hold_q      <= hold_d;
        end
    end

    assign gate_open   = gate_open_q;
    assign gate_height = height_q;
    assign gate_state  = state_q;
    assign gate_owner  = owner_q;
    assign hold_cnt    = hold_q;

endmodule
